ring_rr_arbiter: RTL

Round-robin arbiter that shares one downstream resource among N requesters. It uses a one-hot rotating priority token (a ring counter) to pick the next owner. It sits between the requesting units and the shared resource: it holds a registered one-hot grant per requester and passes priority to the next requester after each tenure. An optional tenure limit revokes the grant from an owner that holds it too long while others wait.

---
 rtl/ring_arb_pkg.sv | 29 ++
 rtl/ring_arb_pick.sv | 29 ++
 rtl/ring_rr_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ring_arb_pkg.sv
// ============================================================================
// Module   : ring_arb_pkg
// Brief    : Shared types, defaults and helpers for the ring round-robin arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ring_arb_pkg;

   localparam int c_DEFAULT_N        = 4;
   localparam int c_DEFAULT_MAX_HOLD = 8;

   typedef logic [0:0] state_t;
   localparam state_t c_IDLE = 1'b0;
   localparam state_t c_BUSY = 1'b1;

   // Zero in maps to zero out, so an empty grant reads back as index 0.
   function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
      logic [31:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = idx | 32'(i);
      end
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ring_arb_pick.sv
// ============================================================================
// Module   : ring_arb_pick
// Brief    : Combinational circular priority picker starting at a one-hot token
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_arb_pick
   import ring_arb_pkg::*;
#(
   parameter int N = c_DEFAULT_N
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] token,
   output logic [N-1:0] pick
);

   logic [2*N-1:0] w_dbl_req;
   logic [2*N-1:0] w_dbl_gnt;

   // Subtracting the token from the doubled request clears the first set bit
   // at or above the token; the mask isolates it, folding the wrap half back.
   assign w_dbl_req = {req, req};
   assign w_dbl_gnt = w_dbl_req & ~(w_dbl_req - {{N{1'b0}}, token});
   assign pick      = w_dbl_gnt[N-1:0] | w_dbl_gnt[2*N-1:N];

endmodule

`default_nettype wire

// File: rtl/ring_rr_arbiter.sv
// ============================================================================
// Module   : ring_rr_arbiter
// Brief    : Round-robin arbiter with a rotating one-hot token and registered
//            grant; optional tenure limit under RING_ARB_HOLD_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_rr_arbiter
   import ring_arb_pkg::*;
#(
   parameter int N        = c_DEFAULT_N,
   parameter int MAX_HOLD = c_DEFAULT_MAX_HOLD
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic                 grant_valid,
   output logic [$clog2(N)-1:0] grant_id,
   output logic [N-1:0]         token,
   output logic                 revoke
);

   localparam int c_ID_W = $clog2(N);

   if (N < 2 || MAX_HOLD < 1) begin : g_bad_params
      $error("ring_rr_arbiter: N must be >= 2 and MAX_HOLD >= 1");
   end

   state_t       r_state;
   logic [N-1:0] r_grant;
   logic [N-1:0] r_token;

   logic         w_owner_req;
   logic         w_expire;
   logic         w_tenure_end;
   logic [N-1:0] w_masked_req;
   logic [N-1:0] w_next_token;
   logic [N-1:0] w_pick_idle;
   logic [N-1:0] w_pick_hand;

   assign w_owner_req  = |(req & r_grant);
   assign w_masked_req = req & ~r_grant;
   assign w_next_token = {r_grant[N-2:0], r_grant[N-1]};
   assign w_tenure_end = (r_state == c_BUSY) && (!w_owner_req || w_expire);

   ring_arb_pick #(.N(N)) u_pick_idle (
      .req   (req),
      .token (r_token),
      .pick  (w_pick_idle)
   );

   ring_arb_pick #(.N(N)) u_pick_hand (
      .req   (w_masked_req),
      .token (w_next_token),
      .pick  (w_pick_hand)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_IDLE;
         r_grant <= '0;
         r_token <= N'(1);
      end else begin
         case (r_state)
            c_IDLE: begin
               r_grant <= w_pick_idle;
               if (|req) r_state <= c_BUSY;
            end
            c_BUSY: begin
               // Release and revoke share one path: rotate past the owner and
               // hand off in the same edge so no empty cycle appears.
               if (w_tenure_end) begin
                  r_token <= w_next_token;
                  r_grant <= w_pick_hand;
                  r_state <= (|w_pick_hand) ? c_BUSY : c_IDLE;
               end
            end
            default: begin
               r_state <= c_IDLE;
               r_grant <= '0;
            end
         endcase
      end
   end

`ifdef RING_ARB_HOLD_LIMIT_EN
   localparam int                c_HOLD_W    = $clog2(MAX_HOLD + 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(MAX_HOLD);
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);

   logic [c_HOLD_W-1:0] r_hold;
   logic                r_revoke;

   // r_hold counts completed cycles, so the current cycle is the last allowed
   // one once it reaches MAX_HOLD-1; it saturates when nobody else waits.
   assign w_expire = (r_hold >= c_HOLD_LAST) && (|w_masked_req);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold   <= '0;
         r_revoke <= 1'b0;
      end else begin
         r_revoke <= (r_state == c_BUSY) && w_owner_req && w_expire;
         if (r_state != c_BUSY || w_tenure_end) begin
            r_hold <= '0;
         end else if (r_hold < c_HOLD_MAX) begin
            r_hold <= r_hold + 1'b1;
         end
      end
   end

   assign revoke = r_revoke;
`else
   assign w_expire = 1'b0;
   assign revoke   = 1'b0;
`endif

   assign grant       = r_grant;
   assign grant_valid = |r_grant;
   assign grant_id    = c_ID_W'(onehot_to_idx(32'(r_grant)));
   assign token       = r_token;

endmodule

`default_nettype wire
